// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, 8N1/8P1 deserialization with parity/stop checks.
// Optional build macro UART_RX_MAJORITY_VOTE_EN selects 2-of-3 majority bit sampling.
module uart_rx (
  input  logic       clck,
  input  logic       rst,
  input  logic       RX_IN,
  input  logic [5:0] prescale,
  input  logic       par_en,
  input  logic       par_typ,
  output logic [7:0] p_data,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned BIT_W  = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   edge_cnt;
  logic [CNT_W-1:0]   presc_l;
  logic [CNT_W-1:0]   half;
  logic [BIT_W-1:0]   bit_cnt;
  logic               par_en_l, par_typ_l;
  logic [DATA_W-1:0]  shift_reg;
  logic               par_bad, stp_bad;
  logic               at_dec_c, at_end_c, bit_val_c, frame_end_c;

  assign half     = presc_l >> 1;
  assign at_dec_c = (edge_cnt == half + CNT_W'(1));
  assign at_end_c = (edge_cnt == presc_l - CNT_W'(1));

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] smp;

  // Samples at s-1 and s; the s+1 sample is taken live at the decision edge.
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      smp <= 2'b11;
    end else if (state != IDLE) begin
      if (edge_cnt == half - CNT_W'(1)) smp[0] <= RX_IN;
      if (edge_cnt == half)             smp[1] <= RX_IN;
    end
  end

  assign bit_val_c = (smp[0] & smp[1]) | (smp[0] & RX_IN) | (smp[1] & RX_IN);
`else
  logic smp;

  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      smp <= 1'b1;
    end else if (state != IDLE && edge_cnt == half) begin
      smp <= RX_IN;
    end
  end

  assign bit_val_c = smp;
`endif

  always_ff @(posedge clck or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_end_c = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN) state_nxt = START;
      end
      START: begin
        if (at_dec_c && bit_val_c) state_nxt = IDLE;
        else if (at_end_c)         state_nxt = DATA;
      end
      DATA: begin
        if (at_end_c && bit_cnt == BIT_W'(DATA_W - 1))
          state_nxt = par_en_l ? PARITY : STOP;
      end
      PARITY: begin
        if (at_end_c) state_nxt = STOP;
      end
      STOP: begin
        if (at_end_c) begin
          state_nxt   = IDLE;
          frame_end_c = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, deserializer, error flags and registered outputs.
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      presc_l    <= '0;
      par_en_l   <= 1'b0;
      par_typ_l  <= 1'b0;
      shift_reg  <= '0;
      par_bad    <= 1'b0;
      stp_bad    <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (state == IDLE) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
        par_bad  <= 1'b0;
        stp_bad  <= 1'b0;
        if (!RX_IN) begin
          presc_l   <= prescale;
          par_en_l  <= par_en;
          par_typ_l <= par_typ;
        end
      end else begin
        edge_cnt <= at_end_c ? '0 : edge_cnt + CNT_W'(1);
        if (state == DATA && at_end_c) bit_cnt <= bit_cnt + BIT_W'(1);
        if (at_dec_c) begin
          case (state)
            DATA:    shift_reg[bit_cnt] <= bit_val_c;
            PARITY:  par_bad <= (bit_val_c != ((^shift_reg) ^ par_typ_l));
            STOP:    stp_bad <= ~bit_val_c;
            default: ;
          endcase
        end
        if (frame_end_c) begin
          if (!par_bad && !stp_bad) begin
            p_data     <= shift_reg;
            data_valid <= 1'b1;
          end
          par_err <= par_bad;
          stp_err <= stp_bad;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames vs. a frame-level model.
module tb_uart_rx;

  logic       clck, rst, rx_in, par_en, par_typ;
  logic [5:0] prescale;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] d;
  } evt_t;

  evt_t       evq[$];
  evt_t       mon_e;
  logic [7:0] exp_pdata;

  uart_rx dut (
    .clck(clck), .rst(rst), .RX_IN(rx_in), .prescale(prescale),
    .par_en(par_en), .par_typ(par_typ), .p_data(p_data),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  initial clck = 1'b0;
  always #5 clck = ~clck;
  always @(posedge clck) cyc <= cyc + 1;

  // Record every cycle on which any outcome flag is high.
  always @(negedge clck) begin
    if (data_valid || par_err || stp_err) begin
      mon_e.cyc = cyc;
      mon_e.dv  = data_valid;
      mon_e.pe  = par_err;
      mon_e.se  = stp_err;
      mon_e.d   = p_data;
      evq.push_back(mon_e);
    end
  end

  function automatic evt_t evt_at(input int idx);
    evt_t e;
    e.cyc = -1; e.dv = 1'b0; e.pe = 1'b0; e.se = 1'b0; e.d = 8'h00;
    if (idx < evq.size()) e = evq[idx];
    return e;
  endfunction

  // Frame outcome from the protocol rules: {data_valid, par_err, stp_err}.
  function automatic logic [2:0] model_flags(input logic [7:0] d, input logic pen,
                                             input logic ptyp, input logic pbit, input logic sbit);
    logic pe, se;
    pe = pen && (pbit != ((^d) ^ ptyp));
    se = !sbit;
    return {!(pe || se), pe, se};
  endfunction

  task automatic drive_bit(input logic v, input int n);
    rx_in = v;
    repeat (n) begin @(posedge clck); #1; end
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic sbit, input int p, input int glitch_bit,
                            input logic scramble, output int start_cyc);
    int s;
    s = p / 2;
    start_cyc = cyc + 1;
    drive_bit(1'b0, p);
    if (scramble) begin
      prescale = 6'(8 << $urandom_range(2));
      par_en   = 1'($urandom);
      par_typ  = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        drive_bit(d[i], s + 1);
        drive_bit(!d[i], 1);
        drive_bit(d[i], p - s - 2);
      end else begin
        drive_bit(d[i], p);
      end
    end
    if (pen) drive_bit(pbit, p);
    drive_bit(sbit, p);
    rx_in = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    repeat (3) @(posedge clck);
    #1;
    checks++;
    if (p_data !== 8'h00) begin failures++; $display("FAIL reset_p_data: got %h expected 00", p_data); end
    checks++;
    if ({data_valid, par_err, stp_err} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %b expected 000", {data_valid, par_err, stp_err});
    end
    rst = 1'b1;
    exp_pdata = 8'h00;
    idle(4);
  endtask

  task automatic test_even_parity;
    int st; evt_t e;
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
    evq.delete();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8, -1, 1'b0, st);
    idle(4);
    e = evt_at(0);
    checks++;
    if (evq.size() != 1) begin failures++; $display("FAIL even_par_count: got %0d expected 1", evq.size()); end
    checks++;
    if (e.cyc != st + 88) begin failures++; $display("FAIL even_par_latency: got %0d expected %0d", e.cyc - st, 88); end
    checks++;
    if ({e.dv, e.pe, e.se, e.d} !== {3'b100, 8'hA5}) begin
      failures++; $display("FAIL even_par_result: got dv%b pe%b se%b d=%h expected dv1 pe0 se0 d=a5", e.dv, e.pe, e.se, e.d);
    end
    exp_pdata = 8'hA5;
  endtask

  task automatic test_wrong_parity;
    int st; evt_t e;
    prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1;
    evq.delete();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16, -1, 1'b0, st);
    idle(4);
    e = evt_at(0);
    checks++;
    if (evq.size() != 1 || e.cyc != st + 176) begin
      failures++; $display("FAIL wrong_par_pulse: got count %0d at %0d expected 1 at 176", evq.size(), e.cyc - st);
    end
    checks++;
    if ({e.dv, e.pe, e.se} !== 3'b010) begin
      failures++; $display("FAIL wrong_par_flags: got dv%b pe%b se%b expected dv0 pe1 se0", e.dv, e.pe, e.se);
    end
    checks++;
    if (p_data !== exp_pdata) begin failures++; $display("FAIL wrong_par_hold: got %h expected %h", p_data, exp_pdata); end
  endtask

  task automatic test_bad_stop;
    int st; evt_t e;
    prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    evq.delete();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 8, -1, 1'b0, st);
    idle(4);
    e = evt_at(0);
    checks++;
    if (evq.size() != 1 || e.cyc != st + 80) begin
      failures++; $display("FAIL bad_stop_pulse: got count %0d at %0d expected 1 at 80", evq.size(), e.cyc - st);
    end
    checks++;
    if ({e.dv, e.pe, e.se} !== 3'b001 || p_data !== exp_pdata) begin
      failures++; $display("FAIL bad_stop_flags: got dv%b pe%b se%b d=%h expected dv0 pe0 se1 d=%h", e.dv, e.pe, e.se, p_data, exp_pdata);
    end
  endtask

  task automatic test_start_glitch;
    int st; evt_t e;
    prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
    evq.delete();
    drive_bit(1'b0, 3);
    idle(48);
    checks++;
    if (evq.size() != 0) begin failures++; $display("FAIL glitch_no_pulse: got %0d pulses expected 0", evq.size()); end
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 16, -1, 1'b0, st);
    idle(4);
    e = evt_at(0);
    checks++;
    if (evq.size() != 1 || e.cyc != st + 160 || {e.dv, e.d} !== {1'b1, 8'h81}) begin
      failures++; $display("FAIL glitch_followup: got count %0d at %0d dv%b d=%h expected 1 at 160 dv1 d=81", evq.size(), e.cyc - st, e.dv, e.d);
    end
    exp_pdata = 8'h81;
  endtask

  task automatic test_back_to_back;
    int st1, st2, gap; evt_t e1, e2; logic [7:0] d3;
    prescale = 6'd32; par_en = 1'b0; par_typ = 1'b0;
    evq.delete();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 32, -1, 1'b0, st1);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 32, -1, 1'b0, st2);
    idle(6);
    e1 = evt_at(0); e2 = evt_at(1);
    gap = e2.cyc - e1.cyc;
    checks++;
    if (evq.size() != 2) begin failures++; $display("FAIL b2b_count: got %0d expected 2", evq.size()); end
    checks++;
    if (e1.cyc != st1 + 320 || {e1.dv, e1.d} !== {1'b1, 8'h3C}) begin
      failures++; $display("FAIL b2b_first: got at %0d dv%b d=%h expected at 320 dv1 d=3c", e1.cyc - st1, e1.dv, e1.d);
    end
    checks++;
    if ((gap != 320 && gap != 321) || {e2.dv, e2.d} !== {1'b1, 8'hC3}) begin
      failures++; $display("FAIL b2b_second: got gap %0d dv%b d=%h expected gap 320..321 dv1 d=c3", gap, e2.dv, e2.d);
    end
    // Third frame is cut by reset halfway through D4.
    d3 = 8'($urandom);
    evq.delete();
    drive_bit(1'b0, 32);
    for (int i = 0; i < 4; i++) drive_bit(d3[i], 32);
    drive_bit(d3[4], 16);
    rst = 1'b0;
    rx_in = 1'b1;
    idle(3);
    checks++;
    if ({p_data, data_valid, par_err, stp_err} !== 11'h000) begin
      failures++; $display("FAIL midreset_outputs: got d=%h dv%b pe%b se%b expected all 0", p_data, data_valid, par_err, stp_err);
    end
    rst = 1'b1;
    exp_pdata = 8'h00;
    idle(384);
    checks++;
    if (evq.size() != 0) begin failures++; $display("FAIL midreset_no_pulse: got %0d pulses expected 0", evq.size()); end
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 32, -1, 1'b0, st1);
    idle(4);
    e1 = evt_at(0);
    checks++;
    if (evq.size() != 1 || e1.cyc != st1 + 320 || {e1.dv, e1.d} !== {1'b1, 8'h7E}) begin
      failures++; $display("FAIL midreset_fresh: got count %0d at %0d dv%b d=%h expected 1 at 320 dv1 d=7e", evq.size(), e1.cyc - st1, e1.dv, e1.d);
    end
    exp_pdata = 8'h7E;
  endtask

  task automatic test_mid_glitch;
    int st; evt_t e; logic [7:0] want;
`ifdef UART_RX_MAJORITY_VOTE_EN
    want = 8'hFF;
`else
    want = 8'hFB;
`endif
    prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    evq.delete();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 8, 2, 1'b0, st);
    idle(4);
    e = evt_at(0);
    checks++;
    if (evq.size() != 1 || {e.dv, e.d} !== {1'b1, want}) begin
      failures++; $display("FAIL mid_glitch: got count %0d dv%b d=%h expected 1 dv1 d=%h", evq.size(), e.dv, e.d, want);
    end
    exp_pdata = want;
  endtask

  task automatic test_random;
    int st, p, n; evt_t e; logic [7:0] d; logic pen, ptyp, pbit, sbit; logic [2:0] fl;
    for (int k = 0; k < 24; k++) begin
      p    = 8 << $urandom_range(2);
      d    = 8'($urandom);
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      pbit = ((^d) ^ ptyp) ^ ($urandom_range(3) == 0);
      sbit = ($urandom_range(4) != 0);
      prescale = 6'(p); par_en = pen; par_typ = ptyp;
      fl = model_flags(d, pen, ptyp, pbit, sbit);
      n  = pen ? 11 : 10;
      evq.delete();
      send_frame(d, pen, pbit, sbit, p, -1, 1'(k % 2), st);
      idle(2 + $urandom_range(3));
      e = evt_at(0);
      if (fl[2]) exp_pdata = d;
      checks++;
      if (evq.size() != 1 || e.cyc != st + n * p) begin
        failures++; $display("FAIL rand%0d_pulse: got count %0d at %0d expected 1 at %0d", k, evq.size(), e.cyc - st, n * p);
      end
      checks++;
      if ({e.dv, e.pe, e.se} !== fl || p_data !== exp_pdata) begin
        failures++; $display("FAIL rand%0d_result: got flags %b d=%h expected flags %b d=%h", k, {e.dv, e.pe, e.se}, p_data, fl, exp_pdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_wrong_parity();
    test_bad_stop();
    test_start_glitch();
    test_back_to_back();
    test_mid_glitch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
